fetch_seq_ctrl: RTL and testbench

- Sequences the fetch-stage PC register against a variable-latency instruction memory that uses a request/grant/response handshake.
- Generates the PC register's En so the PC advances only when an instruction is accepted or a redirect is taken.
- Discards stale responses after a redirect and buffers a returned instruction while decode is stalled.
- Sits between the PC register, the IM port, and the F/D pipeline register; the hazard unit drives Stall, and branch/jump resolution drives Redirect.

---
 rtl/fetch_seq_ctrl.sv | 133 +++++++++++++
 tb/tb_fetch_seq_ctrl.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_seq_ctrl.sv
// rtl/fetch_seq_ctrl.sv - fetch-stage sequencer between PC register, instruction memory and F/D register
module fetch_seq_ctrl #(
    parameter logic [31:0] RESET_PC = 32'h00003000,
    parameter int          CNT_W    = 32
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic [31:0]      PC,
    input  logic             Stall,
    input  logic             Redirect,
    output logic             En,
    output logic             imem_req,
    output logic [31:0]      imem_addr,
    input  logic             imem_gnt,
    input  logic             imem_rvalid,
    input  logic [31:0]      imem_rdata,
    output logic             instr_valid,
    output logic [31:0]      instr,
    output logic [31:0]      instr_pc,
    output logic [CNT_W-1:0] wait_cnt
);

    typedef enum logic [1:0] {IDLE, REQ, WAIT, HOLD} state_t;

    state_t      state, state_nxt;
    logic        kill;
    logic [31:0] inflight_pc;
    logic [31:0] hold_instr;
    logic [31:0] hold_pc;
    logic [31:0] last_pc;

    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    always_ff @(posedge Clk) begin
        if (!Reset) begin
            state       <= IDLE;
            kill        <= 1'b0;
            inflight_pc <= RESET_PC;
            hold_instr  <= 32'h0;
            hold_pc     <= RESET_PC;
            last_pc     <= RESET_PC;
            wait_cnt    <= '0;
        end else begin
            state <= state_nxt;
            case (state)
                REQ: begin
                    if (imem_gnt) begin
                        inflight_pc <= PC;
                        kill        <= Redirect;
                    end
                end
                WAIT: begin
                    if (wait_cnt != '1)
                        wait_cnt <= wait_cnt + CNT_ONE;
                    if (imem_rvalid) begin
                        if (kill) begin
                            kill <= 1'b0;
                        end else if (!Redirect && Stall) begin
                            hold_instr <= imem_rdata;
                            hold_pc    <= inflight_pc;
                        end
                    end else if (Redirect) begin
                        // the pending response now belongs to a squashed path
                        kill <= 1'b1;
                    end
                end
                default: ;
            endcase
            // instr_pc keeps the last PC shown to decode when nothing is valid
            if (instr_valid)
                last_pc <= instr_pc;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: state_nxt = REQ;
            REQ:  if (imem_gnt) state_nxt = WAIT;
            WAIT: begin
                if (imem_rvalid)
                    state_nxt = (kill || Redirect || !Stall) ? REQ : HOLD;
            end
            HOLD: if (Redirect || !Stall) state_nxt = REQ;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        En          = 1'b0;
        imem_req    = 1'b0;
        imem_addr   = PC;
        instr_valid = 1'b0;
        instr       = 32'h0;
        instr_pc    = last_pc;
        if (!Reset) begin
            instr_pc = RESET_PC;
        end else begin
            case (state)
                REQ: begin
                    imem_req = 1'b1;
                    En       = Redirect;
                end
                WAIT: begin
                    if (imem_rvalid) begin
                        if (kill || Redirect) begin
                            En = Redirect;
                        end else if (!Stall) begin
                            instr_valid = 1'b1;
                            instr       = imem_rdata;
                            instr_pc    = inflight_pc;
                            En          = 1'b1;
                        end
                    end else begin
                        En = Redirect;
                    end
                end
                HOLD: begin
                    if (Redirect) begin
                        En = 1'b1;
                    end else begin
                        instr_valid = 1'b1;
                        instr       = hold_instr;
                        instr_pc    = hold_pc;
                        En          = !Stall;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_fetch_seq_ctrl.sv
// tb/tb_fetch_seq_ctrl.sv - directed scoreboard bench for fetch_seq_ctrl
module tb_fetch_seq_ctrl;

    localparam logic [31:0] RST_PC = 32'h00003000;
    localparam int          CW     = 4;

    logic          Clk = 1'b0;
    logic          Reset;
    logic [31:0]   PC;
    logic          Stall, Redirect;
    logic          En, imem_req;
    logic [31:0]   imem_addr;
    logic          imem_gnt, imem_rvalid;
    logic [31:0]   imem_rdata;
    logic          instr_valid;
    logic [31:0]   instr, instr_pc;
    logic [CW-1:0] wait_cnt;

    logic [31:0]   pc_reg;
    logic [31:0]   tgt;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] ins;
    } exp_t;
    exp_t sb[$];

    int total = 0;
    int bad   = 0;

    fetch_seq_ctrl #(.RESET_PC(RST_PC), .CNT_W(CW)) dut (
        .Clk(Clk), .Reset(Reset), .PC(PC), .Stall(Stall), .Redirect(Redirect),
        .En(En), .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_gnt(imem_gnt), .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
        .instr_valid(instr_valid), .instr(instr), .instr_pc(instr_pc),
        .wait_cnt(wait_cnt)
    );

    always #5 Clk = ~Clk;

    // PC register the block controls
    always @(posedge Clk) begin
        if (!Reset)   pc_reg <= RST_PC;
        else if (En)  pc_reg <= Redirect ? tgt : pc_reg + 32'd4;
    end
    assign PC = pc_reg;

    function automatic logic [31:0] mdata(input logic [31:0] a);
        return a ^ 32'h5A5A0000;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // sample at negedge; consume scoreboard on each accepted instruction
    task automatic settle();
        exp_t e;
        @(negedge Clk);
        if (Reset && instr_valid && !Stall && !Redirect) begin
            total++;
            assert (sb.size() > 0) else begin
                bad++;
                $error("FAIL sb_unexpected observed=%h expected=none", instr_pc);
            end
            if (sb.size() > 0) begin
                e = sb.pop_front();
                chk("sb_pc", instr_pc, e.pc);
                chk("sb_instr", instr, e.ins);
            end
        end
    endtask

    task automatic adv();
        @(posedge Clk);
        #1;
    endtask

    task automatic do_reset();
        Reset = 1'b0; Stall = 1'b0; Redirect = 1'b0;
        imem_gnt = 1'b0; imem_rvalid = 1'b0; imem_rdata = 32'h0;
        settle();
        chk("rst_en", En, 1'b0);
        chk("rst_req", imem_req, 1'b0);
        chk("rst_iv", instr_valid, 1'b0);
        chk("rst_instr", instr, 32'h0);
        chk("rst_pc", instr_pc, RST_PC);
        adv();
        settle();
        adv();
        chk("rst_wcnt", wait_cnt, 0);
        Reset = 1'b1;
        settle();
        chk("idle_req", imem_req, 1'b0);
        chk("idle_en", En, 1'b0);
        adv();
    endtask

    task automatic fetch(input int lat, input int stall_n, input logic [31:0] epc,
                         input logic [31:0] data);
        Stall = 1'b0; Redirect = 1'b0; imem_rvalid = 1'b0; imem_gnt = 1'b1;
        settle();
        chk("req", imem_req, 1'b1);
        chk("addr", imem_addr, epc);
        chk("en_gnt", En, 1'b0);
        sb.push_back('{epc, data});
        adv();
        imem_gnt = 1'b0;
        for (int i = 1; i < lat; i++) begin
            settle();
            chk("en_wait", En, 1'b0);
            chk("req_wait", imem_req, 1'b0);
            chk("pc_held", PC, epc);
            adv();
        end
        imem_rvalid = 1'b1; imem_rdata = data; Stall = (stall_n > 0);
        settle();
        chk("en_rv", En, stall_n == 0);
        chk("iv_rv", instr_valid, stall_n == 0);
        adv();
        imem_rvalid = 1'b0; imem_rdata = 32'h0;
        if (stall_n > 0) begin
            for (int i = 1; i < stall_n; i++) begin
                settle();
                chk("hold_iv", instr_valid, 1'b1);
                chk("hold_instr", instr, data);
                chk("hold_pc", instr_pc, epc);
                chk("hold_en", En, 1'b0);
                adv();
            end
            Stall = 1'b0;
            settle();
            chk("rel_en", En, 1'b1);
            chk("rel_iv", instr_valid, 1'b1);
            adv();
        end
        chk("pc_adv", PC, epc + 32'd4);
    endtask

    initial begin
        tgt = 32'h0;
        do_reset();

        // zero-wait memory, back-to-back fetches
        fetch(1, 0, 32'h3000, mdata(32'h3000));
        fetch(1, 0, 32'h3004, mdata(32'h3004));
        fetch(1, 0, 32'h3008, mdata(32'h3008));
        chk("wcnt_zero_wait", wait_cnt, 3);

        // three-cycle response latency
        do_reset();
        fetch(3, 0, 32'h3000, mdata(32'h3000));
        chk("wcnt_lat3", wait_cnt, 3);

        // decode stalled for four cycles when the response lands
        fetch(1, 4, 32'h3004, 32'h24080005);

        // redirect while waiting: late response must be dropped
        imem_gnt = 1'b1;
        settle(); chk("rd_addr", imem_addr, 32'h3008); adv();
        imem_gnt = 1'b0; Redirect = 1'b1; tgt = 32'h3100;
        settle(); chk("rd_en", En, 1'b1); chk("rd_iv", instr_valid, 1'b0); adv();
        Redirect = 1'b0; imem_rvalid = 1'b1; imem_rdata = 32'hDEADBEEF;
        settle(); chk("killed_iv", instr_valid, 1'b0); chk("killed_en", En, 1'b0); adv();
        imem_rvalid = 1'b0;
        fetch(1, 0, 32'h3100, mdata(32'h3100));

        // redirect in the same cycle as the response
        imem_gnt = 1'b1;
        settle(); chk("rs_addr", imem_addr, 32'h3104); adv();
        imem_gnt = 1'b0; imem_rvalid = 1'b1; imem_rdata = 32'h11111111;
        Redirect = 1'b1; tgt = 32'h3200;
        settle(); chk("rs_iv", instr_valid, 1'b0); chk("rs_en", En, 1'b1); adv();
        imem_rvalid = 1'b0; Redirect = 1'b0;
        fetch(1, 0, 32'h3200, mdata(32'h3200));

        // redirect while holding a stalled instruction
        imem_gnt = 1'b1;
        settle(); chk("rh_addr", imem_addr, 32'h3204); adv();
        imem_gnt = 1'b0; imem_rvalid = 1'b1; imem_rdata = 32'h22222222; Stall = 1'b1;
        settle(); chk("rh_iv_rv", instr_valid, 1'b0); adv();
        imem_rvalid = 1'b0;
        settle(); chk("rh_hold_iv", instr_valid, 1'b1); chk("rh_hold_instr", instr, 32'h22222222); adv();
        Redirect = 1'b1; tgt = 32'h3300;
        settle(); chk("rh_iv", instr_valid, 1'b0); chk("rh_en", En, 1'b1); adv();
        Redirect = 1'b0; Stall = 1'b0;
        fetch(1, 0, 32'h3300, mdata(32'h3300));

        // long latency saturates the wait counter
        fetch(20, 0, 32'h3304, mdata(32'h3304));
        chk("wcnt_sat", wait_cnt, 15);

        // reset in the middle of a fetch
        imem_gnt = 1'b1;
        settle(); chk("rw_addr", imem_addr, 32'h3308); adv();
        imem_gnt = 1'b0; Reset = 1'b0;
        settle();
        chk("rw_req", imem_req, 1'b0); chk("rw_iv", instr_valid, 1'b0);
        chk("rw_en", En, 1'b0); chk("rw_pc", instr_pc, RST_PC);
        adv();
        Reset = 1'b1;
        settle();
        chk("rw_wcnt", wait_cnt, 0); chk("rw_idle_req", imem_req, 1'b0);
        chk("rw_idle_iv", instr_valid, 1'b0);
        adv();
        fetch(1, 0, 32'h3000, mdata(32'h3000));

        total++;
        assert (sb.size() == 0) else begin
            bad++;
            $error("FAIL sb_leftover observed=%0d expected=0", sb.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
